mem_bus_arbiter: RTL and testbench

//  Shares the single memory/IO bus (mem_addr/mem_ctrl/mem_wd/mem_we/mem_rd) between two masters:
//  M0 = core MEM-stage data port, M1 = DMA/debug loader. Round-robin, one transaction at a time.

---
 rtl/mem_bus_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one memory/IO bus between two masters (M0 = core data port,
// M1 = DMA/debug loader). Round-robin, one transaction at a time: each
// accepted request is latched, held on the bus for LAT cycles and answered
// with a single-cycle ack. Every output comes straight from a register.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  // master 0
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [CTRL_W-1:0] m0_ctrl_i,
  input  logic [DATA_W-1:0] m0_wd_i,
  input  logic              m0_we_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_gnt_o,
  // master 1
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [CTRL_W-1:0] m1_ctrl_i,
  input  logic [DATA_W-1:0] m1_wd_i,
  input  logic              m1_we_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_gnt_o,
  // shared bus
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [CTRL_W-1:0] mem_ctrl_o,
  output logic [DATA_W-1:0] mem_wd_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rd_i
);

  // A zero-length bus phase has no cycle in which read data could be sampled,
  // and the 4-bit down-counter cannot hold more than 15 bus cycles.
  if ((LAT < 1) || (LAT > 15)) begin : g_lat_check
    $error("mem_bus_arbiter: LAT must be in 1..15");
  end

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e              state_q,    state_d;
  logic [3:0]          cnt_q,      cnt_d;
  logic                last_q,     last_d;     // owner of the most recent grant
  logic                owner_q,    owner_d;    // 0 = M0, 1 = M1
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [CTRL_W-1:0]   mem_ctrl_q, mem_ctrl_d;
  logic [DATA_W-1:0]   mem_wd_q,   mem_wd_d;
  logic                mem_we_q,   mem_we_d;   // also the latched direction
  logic                m0_ack_q,   m0_ack_d;
  logic                m1_ack_q,   m1_ack_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                m0_gnt_q,   m0_gnt_d;
  logic                m1_gnt_q,   m1_gnt_d;

  logic                grant_vld;
  logic                grant_sel;

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      last_q     <= 1'b1;                 // M0 wins the first tie
      owner_q    <= 1'b0;
      mem_addr_q <= {ADDR_W{1'b0}};
      mem_ctrl_q <= {CTRL_W{1'b0}};
      mem_wd_q   <= {DATA_W{1'b0}};
      mem_we_q   <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= {DATA_W{1'b0}};
      m1_rdata_q <= {DATA_W{1'b0}};
      m0_gnt_q   <= 1'b0;
      m1_gnt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      mem_addr_q <= mem_addr_d;
      mem_ctrl_q <= mem_ctrl_d;
      mem_wd_q   <= mem_wd_d;
      mem_we_q   <= mem_we_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_gnt_q   <= m0_gnt_d;
      m1_gnt_q   <= m1_gnt_d;
    end
  end

  // Arbitration, bus sequencing and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    owner_d    = owner_q;
    mem_addr_d = mem_addr_q;
    mem_ctrl_d = mem_ctrl_q;
    mem_wd_d   = mem_wd_q;
    mem_we_d   = mem_we_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_gnt_d   = m0_gnt_q;
    m1_gnt_d   = m1_gnt_q;
    grant_vld  = 1'b0;
    grant_sel  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // On a tie the master that did not win last time goes next.
        if (m0_req_i && m1_req_i) begin
          grant_vld = 1'b1;
          grant_sel = ~last_q;
        end else if (m0_req_i) begin
          grant_vld = 1'b1;
          grant_sel = 1'b0;
        end else if (m1_req_i) begin
          grant_vld = 1'b1;
          grant_sel = 1'b1;
        end else begin
          grant_vld = 1'b0;
          grant_sel = 1'b0;
        end

        if (grant_vld) begin
          state_d    = ST_ACCESS;
          cnt_d      = LAT_M1;
          owner_d    = grant_sel;
          last_d     = grant_sel;
          mem_addr_d = grant_sel ? m1_addr_i : m0_addr_i;
          mem_ctrl_d = grant_sel ? m1_ctrl_i : m0_ctrl_i;
          mem_wd_d   = grant_sel ? m1_wd_i   : m0_wd_i;
          mem_we_d   = grant_sel ? m1_we_i   : m0_we_i;
          m0_gnt_d   = ~grant_sel;
          m1_gnt_d   = grant_sel;
        end else begin
          state_d    = ST_IDLE;
          mem_ctrl_d = {CTRL_W{1'b0}};
          mem_we_d   = 1'b0;
          m0_gnt_d   = 1'b0;
          m1_gnt_d   = 1'b0;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last bus cycle: capture read data, release the bus, ack next cycle.
          state_d    = ST_RESP;
          mem_ctrl_d = {CTRL_W{1'b0}};
          mem_we_d   = 1'b0;
          m0_ack_d   = ~owner_q;
          m1_ack_d   = owner_q;
          if (!mem_we_q && !owner_q) begin
            m0_rdata_d = mem_rd_i;
          end else if (!mem_we_q && owner_q) begin
            m1_rdata_d = mem_rd_i;
          end else begin
            m0_rdata_d = m0_rdata_q;
            m1_rdata_d = m1_rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        // Ack is visible this cycle; no arbitration until back in IDLE.
        state_d  = ST_IDLE;
        m0_gnt_d = 1'b0;
        m1_gnt_d = 1'b0;
      end

      default: begin
        state_d    = ST_IDLE;
        mem_ctrl_d = {CTRL_W{1'b0}};
        mem_we_d   = 1'b0;
        m0_gnt_d   = 1'b0;
        m1_gnt_d   = 1'b0;
      end
    endcase
  end

  assign mem_addr_o = mem_addr_q;
  assign mem_ctrl_o = mem_ctrl_q;
  assign mem_wd_o   = mem_wd_q;
  assign mem_we_o   = mem_we_q;
  assign m0_ack_o   = m0_ack_q;
  assign m1_ack_o   = m1_ack_q;
  assign m0_rdata_o = m0_rdata_q;
  assign m1_rdata_o = m1_rdata_q;
  assign m0_gnt_o   = m0_gnt_q;
  assign m1_gnt_o   = m1_gnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter. Instance "a" (LAT=2) is checked every
// cycle against a transaction-timeline model; instance "b" (LAT=1) shares the
// inputs and is checked with literal expectations in the single-cycle test.
module tb_mem_bus_arbiter;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd, mem_rd;
  logic [3:0]  m0_ctrl, m1_ctrl;

  logic        a_m0_ack, a_m0_gnt, a_m1_ack, a_m1_gnt, a_mem_we;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wd;
  logic [3:0]  a_mem_ctrl;
  logic        b_m0_ack, b_m0_gnt, b_m1_ack, b_m1_gnt, b_mem_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wd;
  logic [3:0]  b_mem_ctrl;

  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .CTRL_W(4), .LAT(LAT_A)) u_a (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_ctrl_i(m0_ctrl), .m0_wd_i(m0_wd), .m0_we_i(m0_we),
    .m0_ack_o(a_m0_ack), .m0_rdata_o(a_m0_rdata), .m0_gnt_o(a_m0_gnt),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_ctrl_i(m1_ctrl), .m1_wd_i(m1_wd), .m1_we_i(m1_we),
    .m1_ack_o(a_m1_ack), .m1_rdata_o(a_m1_rdata), .m1_gnt_o(a_m1_gnt),
    .mem_addr_o(a_mem_addr), .mem_ctrl_o(a_mem_ctrl), .mem_wd_o(a_mem_wd), .mem_we_o(a_mem_we),
    .mem_rd_i(mem_rd)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .CTRL_W(4), .LAT(LAT_B)) u_b (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_ctrl_i(m0_ctrl), .m0_wd_i(m0_wd), .m0_we_i(m0_we),
    .m0_ack_o(b_m0_ack), .m0_rdata_o(b_m0_rdata), .m0_gnt_o(b_m0_gnt),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_ctrl_i(m1_ctrl), .m1_wd_i(m1_wd), .m1_we_i(m1_we),
    .m1_ack_o(b_m1_ack), .m1_rdata_o(b_m1_rdata), .m1_gnt_o(b_m1_gnt),
    .mem_addr_o(b_mem_addr), .mem_ctrl_o(b_mem_ctrl), .mem_wd_o(b_mem_wd), .mem_we_o(b_mem_we),
    .mem_rd_i(mem_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // advance to just after the next rising edge (start of the next cycle)
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- model: timeline of the transaction in flight ----------------
  // A grant sampled at the end of cycle S puts the bus up in S+1..S+LAT,
  // acks in S+LAT+1, and the arbiter is free again from S+LAT+2.
  bit          md_busy, md_own, md_we, md_last;
  int          md_start, cyc;
  logic [3:0]  md_ctrl;
  logic [31:0] md_addr, md_wd;
  logic [31:0] md_rdata [2];

  initial begin
    int          ph;
    logic [3:0]  e_ctrl;
    logic        e_we;
    logic [1:0]  e_ack, e_gnt;
    cyc = 0;
    md_busy = 1'b0; md_last = 1'b1; md_own = 1'b0; md_we = 1'b0; md_start = 0;
    md_ctrl = 4'h0; md_addr = 32'h0; md_wd = 32'h0;
    md_rdata[0] = 32'h0; md_rdata[1] = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        md_busy = 1'b0; md_last = 1'b1; md_ctrl = 4'h0; md_we = 1'b0;
        md_addr = 32'h0; md_wd = 32'h0;
        md_rdata[0] = 32'h0; md_rdata[1] = 32'h0;
      end
      ph     = md_busy ? (cyc - md_start) : 0;
      e_ctrl = 4'h0; e_we = 1'b0; e_ack = 2'b00; e_gnt = 2'b00;
      if (md_busy && ph >= 1 && ph <= LAT_A) begin
        e_ctrl = md_ctrl; e_we = md_we; e_gnt[md_own] = 1'b1;
      end else if (md_busy && ph == LAT_A + 1) begin
        e_gnt[md_own] = 1'b1; e_ack[md_own] = 1'b1;
      end
      chk("mdl_mem_addr", a_mem_addr, md_addr);
      chk("mdl_mem_wd",   a_mem_wd,   md_wd);
      chk("mdl_mem_ctrl", {28'h0, a_mem_ctrl}, {28'h0, e_ctrl});
      chk("mdl_mem_we",   {31'h0, a_mem_we},   {31'h0, e_we});
      chk("mdl_m0_ack",   {31'h0, a_m0_ack},   {31'h0, e_ack[0]});
      chk("mdl_m1_ack",   {31'h0, a_m1_ack},   {31'h0, e_ack[1]});
      chk("mdl_m0_gnt",   {31'h0, a_m0_gnt},   {31'h0, e_gnt[0]});
      chk("mdl_m1_gnt",   {31'h0, a_m1_gnt},   {31'h0, e_gnt[1]});
      chk("mdl_m0_rdata", a_m0_rdata, md_rdata[0]);
      chk("mdl_m1_rdata", a_m1_rdata, md_rdata[1]);
      if (rst_n) begin
        if (md_busy) begin
          if (ph == LAT_A && !md_we) md_rdata[md_own] = mem_rd;
          if (ph == LAT_A + 1) md_busy = 1'b0;
        end else if (m0_req || m1_req) begin
          md_own   = (m0_req && m1_req) ? !md_last : m1_req;
          md_addr  = md_own ? m1_addr : m0_addr;
          md_wd    = md_own ? m1_wd   : m0_wd;
          md_ctrl  = md_own ? m1_ctrl : m0_ctrl;
          md_we    = md_own ? m1_we   : m0_we;
          md_last  = md_own;
          md_start = cyc;
          md_busy  = 1'b1;
        end
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wd = 32'h0; m0_ctrl = 4'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wd = 32'h0; m1_ctrl = 4'h0;
    mem_rd = 32'h0;
    tick(2);
    @(negedge clk);
    chk("rst_mem_ctrl", {28'h0, a_mem_ctrl}, 32'h0);
    chk("rst_m0_gnt",   {31'h0, a_m0_gnt},   32'h0);
    chk("rst_mem_addr", a_mem_addr, 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // 1 + 5: M0 read of 0x100, address changed after grant is ignored
    m0_req = 1'b1; m0_addr = 32'h100; m0_ctrl = 4'b0010; m0_we = 1'b0; m0_wd = 32'h1111;
    mem_rd = 32'hDEADBEEF;
    tick(1);                                     // c1
    @(negedge clk);
    chk("t1_addr_c1", a_mem_addr, 32'h100);
    chk("t1_gnt_c1",  {31'h0, a_m0_gnt}, 32'h1);
    tick(1);                                     // c2
    m0_addr = 32'h300;
    @(negedge clk);
    chk("t5_addr_c2", a_mem_addr, 32'h100);
    tick(1);                                     // c3
    m0_req = 1'b0;
    @(negedge clk);
    chk("t1_ack_c3",   {31'h0, a_m0_ack}, 32'h1);
    chk("t1_rdata_c3", a_m0_rdata, 32'hDEADBEEF);
    chk("t5_addr_c3",  a_mem_addr, 32'h100);
    tick(1);                                     // c4
    @(negedge clk);
    chk("t1_ack_c4", {31'h0, a_m0_ack}, 32'h0);
    chk("t1_gnt_c4", {31'h0, a_m0_gnt}, 32'h0);

    // 3: M1 write 0x55AA to 0x200
    tick(1);                                     // c0
    m1_req = 1'b1; m1_addr = 32'h200; m1_ctrl = 4'b0101; m1_we = 1'b1; m1_wd = 32'h55AA;
    tick(1);                                     // c1
    @(negedge clk);
    chk("t3_we_c1",   {31'h0, a_mem_we}, 32'h1);
    chk("t3_ctrl_c1", {28'h0, a_mem_ctrl}, 32'h5);
    chk("t3_wd_c1",   a_mem_wd, 32'h55AA);
    chk("t3_m0gnt",   {31'h0, a_m0_gnt}, 32'h0);
    tick(1);                                     // c2
    @(negedge clk);
    chk("t3_we_c2", {31'h0, a_mem_we}, 32'h1);
    tick(1);                                     // c3
    m1_req = 1'b0;
    @(negedge clk);
    chk("t3_ack_c3",   {31'h0, a_m1_ack}, 32'h1);
    chk("t3_rdata_c3", a_m1_rdata, 32'h0);
    chk("t3_we_c3",    {31'h0, a_mem_we}, 32'h0);

    // 2: after reset, both masters hold requests -> M0, M1, M0
    tick(1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t2_rst_rdata", a_m0_rdata, 32'h0);
    tick(1);
    rst_n = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h400; m0_ctrl = 4'b0010; m0_we = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h500; m1_ctrl = 4'b0010; m1_we = 1'b0;
    for (int k = 0; k < 12; k++) begin
      mem_rd = 32'h1000_0000 + 32'(k);
      @(negedge clk);
      chk("t2_gnt_excl", {31'h0, a_m0_gnt & a_m1_gnt}, 32'h0);
      case (k)
        1: chk("t2_gnt_m0_c1", {31'h0, a_m0_gnt}, 32'h1);
        3: begin
          chk("t2_ack_m0_c3",   {31'h0, a_m0_ack}, 32'h1);
          chk("t2_rdata_m0_c3", a_m0_rdata, 32'h1000_0002);
        end
        5: chk("t2_gnt_m1_c5", {31'h0, a_m1_gnt}, 32'h1);
        7: begin
          chk("t2_ack_m1_c7",   {31'h0, a_m1_ack}, 32'h1);
          chk("t2_rdata_m1_c7", a_m1_rdata, 32'h1000_0006);
        end
        11: begin
          chk("t2_ack_m0_c11",   {31'h0, a_m0_ack}, 32'h1);
          chk("t2_rdata_m0_c11", a_m0_rdata, 32'h1000_000A);
        end
        default: ;
      endcase
      tick(1);
    end

    // 4: reset during ACCESS of an M0 read; next tie must still go to M0
    m1_req = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h600; mem_rd = 32'hA1B2C3D4;   // c0
    tick(1);                                                   // c1
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_addr_rst", a_mem_addr, 32'h0);
    chk("t4_gnt_rst",  {31'h0, a_m0_gnt}, 32'h0);
    chk("t4_ctrl_rst", {28'h0, a_mem_ctrl}, 32'h0);
    tick(1);                                                   // c2
    rst_n = 1'b1;
    m0_addr = 32'h700; m1_req = 1'b1; m1_addr = 32'h780;
    @(negedge clk);
    chk("t4_noack_c2", {31'h0, a_m0_ack}, 32'h0);
    tick(1);                                                   // c3
    @(negedge clk);
    chk("t4_tie_m0",   {31'h0, a_m0_gnt}, 32'h1);
    chk("t4_tie_m1",   {31'h0, a_m1_gnt}, 32'h0);
    chk("t4_noack_c3", {31'h0, a_m0_ack}, 32'h0);
    chk("t4_addr_c3",  a_mem_addr, 32'h700);
    tick(1);                                                   // c4
    @(negedge clk);
    chk("t4_noack_c4", {31'h0, a_m0_ack}, 32'h0);
    tick(1);                                                   // c5
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    chk("t4_ack_c5",   {31'h0, a_m0_ack}, 32'h1);
    chk("t4_rdata_c5", a_m0_rdata, 32'hA1B2C3D4);

    // 6: LAT=1 instance, M1 read of 0x40; requester drops req mid-transaction
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);                                                   // c0
    m1_req = 1'b1; m1_addr = 32'h40; m1_ctrl = 4'b0100; m1_we = 1'b0; mem_rd = 32'h12345678;
    tick(1);                                                   // c1
    @(negedge clk);
    chk("t6_addr_c1", b_mem_addr, 32'h40);
    chk("t6_ctrl_c1", {28'h0, b_mem_ctrl}, 32'h4);
    chk("t6_gnt_c1",  {31'h0, b_m1_gnt}, 32'h1);
    tick(1);                                                   // c2
    m1_req = 1'b0;
    @(negedge clk);
    chk("t6_ack_c2",   {31'h0, b_m1_ack}, 32'h1);
    chk("t6_rdata_c2", b_m1_rdata, 32'h12345678);
    chk("t6_ctrl_c2",  {28'h0, b_mem_ctrl}, 32'h0);
    tick(1);                                                   // c3
    @(negedge clk);
    chk("t6_ack_c3",   {31'h0, b_m1_ack}, 32'h0);
    chk("t6_gnt_c3",   {31'h0, b_m1_gnt}, 32'h0);
    chk("t6_a_ack_c3", {31'h0, a_m1_ack}, 32'h1);
    chk("t6_a_rd_c3",  a_m1_rdata, 32'h12345678);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
